instr_fetch_unit: RTL

//  Producer side of the instruction register: owns the PC and runs a one-word fetch

---
 rtl/instr_fetch_unit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, runs a one-word req/ack fetch against
// instruction memory and strobes the fetched word into the instruction register.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_go,
  input  logic        pc_load,
  input  logic [31:0] pc_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ir_d,
  output logic        ir_write,
  output logic [31:0] pc,
  output logic        busy,
  output logic        fetch_err
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt;
  logic          pend_valid;
  logic [31:0]   pend_pc;

  logic          in_misaligned;
  logic [31:0]   in_target;
  logic          timeout;
  logic [31:0]   done_pc;

  assign in_misaligned = (pc_in[1:0] != 2'b00);
  assign in_target     = {pc_in[31:2], 2'b00};
  assign timeout       = (wait_cnt == CW'(MAX_WAIT - 1));

  // A redirect arriving in the same cycle as the ack is the newest one and wins.
  always_comb begin
    if (pc_load)         done_pc = in_target;
    else if (pend_valid) done_pc = pend_pc;
    else                 done_pc = pc + 32'd4;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (pc_load)       state_next = in_misaligned ? S_ERR : S_IDLE;
        else if (fetch_go) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ack)      state_next = (fetch_err || (pc_load && in_misaligned)) ? S_ERR : S_IDLE;
        else if (timeout) state_next = S_ERR;
      end
      S_ERR: begin
        if (pc_load && !in_misaligned) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath registers: PC, address, instruction word, error and wait tracking.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: non-blocking assignments keep every register updated from pre-edge values.
      pc         <= RESET_PC;
      mem_addr   <= RESET_PC;
      ir_d       <= '0;
      ir_write   <= 1'b0;
      fetch_err  <= 1'b0;
      wait_cnt   <= '0;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else begin
      ir_write <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pc_load) begin
            pc <= in_target;
            if (in_misaligned) fetch_err <= 1'b1;
          end else if (fetch_go) begin
            mem_addr <= pc;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (pc_load && in_misaligned) fetch_err <= 1'b1;
          if (mem_ack) begin
            ir_d       <= mem_rdata;
            ir_write   <= 1'b1;
            pc         <= done_pc;
            pend_valid <= 1'b0;
          end else if (timeout) begin
            fetch_err  <= 1'b1;
            pend_valid <= 1'b0;
            wait_cnt   <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (pc_load) begin
              pend_valid <= 1'b1;
              pend_pc    <= in_target;
            end
          end
        end
        S_ERR: begin
          if (pc_load && !in_misaligned) begin
            pc        <= in_target;
            fetch_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode the registered state, so they change only on clock edges.
  always_comb begin
    busy    = (state == S_WAIT);
    mem_req = (state == S_WAIT);
  end

endmodule
